// File: rtl/apb_dual_master_ctrl.sv
// APB master that arbitrates two local requesters round-robin and runs the
// SETUP/ACCESS sequence, decoding the slave from the address MSB and aborting stalled accesses.
module apb_dual_master_ctrl #(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              PSELECT1,
   output logic              PSELECT2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              done0_q, done0_d, done1_q, done1_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              psel1_q, psel1_d, psel2_q, psel2_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              win0;
   logic [ADDR_W-1:0] win_addr;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      psel1_d   = psel1_q;
      psel2_d   = psel2_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      // On a tie the requester not served last wins; last_q = 1 favours req0.
      win0      = req0 & (~req1 | last_q);
      win_addr  = win0 ? addr0 : addr1;
      case (state_q)
         IDLE: begin
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
            if (req0 | req1) begin
               owner_d  = ~win0;
               last_d   = ~win0;
               pwrite_d = win0 ? wr0 : wr1;
               paddr_d  = win_addr;
               pwdata_d = win0 ? wdata0 : wdata1;
               psel1_d  = ~win_addr[ADDR_W-1];
               psel2_d  = win_addr[ADDR_W-1];
               gnt0_d   = win0;
               gnt1_d   = ~win0;
               cnt_d    = '0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               if (!pwrite_q) rdata_d = PRDATA;
               err_d     = PSLVERR;
               done0_d   = ~owner_q;
               done1_d   = owner_q;
               psel1_d   = 1'b0;
               psel2_d   = 1'b0;
               penable_d = 1'b0;
               state_d   = IDLE;
            end else if (cnt_q == TMO) begin
               rdata_d   = '0;
               err_d     = 1'b1;
               done0_d   = ~owner_q;
               done1_d   = owner_q;
               psel1_d   = 1'b0;
               psel2_d   = 1'b0;
               penable_d = 1'b0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         psel1_q   <= 1'b0;
         psel2_q   <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         psel1_q   <= psel1_d;
         psel2_q   <= psel2_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign rdata    = rdata_q;
   assign err      = err_q;
   assign PSELECT1 = psel1_q;
   assign PSELECT2 = psel2_q;
   assign PENABLE  = penable_q;
   assign PWRITE   = pwrite_q;
   assign PADDR    = paddr_q;
   assign PWDATA   = pwdata_q;
endmodule

// File: doc/apb_dual_master_ctrl.md
# apb_dual_master_ctrl

APB bus controller that sequences transfers onto the shared APB bus for the two memory slaves, Slave1 and Slave2, and arbitrates that bus between two local requesters. It accepts simple request/grant/done transactions from each requester, applies round-robin arbitration, and generates the APB SETUP/ACCESS phases. It decodes the slave select from PADDR[6], and enforces a wait-state timeout. It sits between the system-side requesters and the APB slaves.

## Interface
- ADDR_W, 7, APB address width; PADDR[ADDR_W-1] selects the slave.
- DATA_W, 8, APB data width.
- TIMEOUT, 15, maximum ACCESS wait cycles with PREADY low before abort (1..255).

Ports:
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESET  in  1  asynchronous, active-low reset.
- req0, req1  in  1  transfer request; held high until the matching gnt is seen.
- wr0, wr1  in  1  1 = write, 0 = read; valid while req is high.
- addr0, addr1  in  ADDR_W  transfer address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  one-cycle pulse; request accepted, inputs already captured.
- done0, done1  out  1  one-cycle pulse; transfer completed.
- rdata  out  DATA_W  read data of the last completed transfer.
- err  out  1  error flag of the last completed transfer; valid with done.
- PSELECT1, PSELECT2  out  1  slave selects.
- PENABLE, PWRITE  out  1  APB enable and direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  read data from the selected slave (muxed externally).
- PREADY, PSLVERR  in  1  slave ready and slave error.

## Operation
- FSM states are IDLE, SETUP and ACCESS.
- **IDLE**
  - If any req is high, arbitrate, capture the winner's wr/addr/wdata into the APB output registers, record the owner, and go to SETUP.
  - Otherwise stay in IDLE. APB outputs keep their last values; PSELx = 0 and PENABLE = 0.
- **Arbitration**
  - A single requester always wins.
  - When both requesters are high, the winner is the one not served last.
  - The last-served pointer resets to "1", so req0 wins the first tie.
- **SETUP**
  - PSELECT1 = ~PADDR[ADDR_W-1] and PSELECT2 = PADDR[ADDR_W-1]; PENABLE = 0.
  - The owner's gnt is high for this cycle only.
  - Always go to ACCESS.
- **ACCESS**
  - PSELx is held and PENABLE = 1. PADDR, PWDATA and PWRITE are stable through SETUP and ACCESS.
  - If PREADY = 1: register rdata = PRDATA on a read (rdata unchanged on a write), register err = PSLVERR, pulse the owner's done next cycle, and go to IDLE.
  - If PREADY = 0 and the wait counter < TIMEOUT: increment the counter and stay in ACCESS.
  - If PREADY = 0 and the counter == TIMEOUT: abort. Drop PSELx and PENABLE, set rdata = 0 and err = 1, pulse done, and go to IDLE.
- The wait counter clears on entry to SETUP. Its width is the minimum needed to hold TIMEOUT.
- A requester that is not granted keeps req high and is served in a later arbitration. Requests are never dropped.
- Reset (asserted asynchronously, at any time including mid-transfer):
  - FSM goes to IDLE.
  - All outputs go to 0, including PADDR, PWDATA, rdata and err.
  - The counter clears and the pointer returns to "1".
  - No done is issued for the interrupted transfer.

## Timing
- Request seen high at edge N, in IDLE:
  - SETUP during cycle N+1, with gnt high.
  - ACCESS during cycle N+2.
  - With zero-wait PREADY, done high during cycle N+3 (IDLE).
- The requester drops req after seeing gnt. A req still high in the IDLE cycle carrying done is treated as a new request.
- Back-to-back transfers take 3 cycles each (IDLE, SETUP, ACCESS). The IDLE cycle coincides with the previous done.
- Each wait cycle extends ACCESS by one cycle.
- An abort occurs after exactly TIMEOUT low-PREADY cycles followed by one more low sample. ACCESS therefore lasts TIMEOUT+1 cycles.
- done0 and done1 are never high together. gnt0 and gnt1 are never high together.
- rdata and err hold until the next completion.

## Test plan
- **Single write:** req0, wr0 = 1, addr0 = 0x05, wdata0 = 0xA5, PREADY tied high.
  - PSELECT1 high for 2 cycles, PENABLE high in cycle 2, PWDATA = 0xA5.
  - gnt0 pulses in SETUP; done0 one cycle after ACCESS, with err = 0.
- **Read, other slave:** req1, wr1 = 0, addr1 = 0x45, slave returns 0x3C.
  - PSELECT2 high, PSELECT1 low.
  - done1 pulses with rdata = 0x3C and err = 0.
- **Tie after reset:** req0 and req1 high simultaneously and continuously for 4 transfers.
  - Grant order is 0, 1, 0, 1; each transfer takes 3 cycles; no request is lost.
- **Wait states:** PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x77.
  - ACCESS lasts 4 cycles; done with rdata = 0x77 and err = 0.
- **Timeout:** TIMEOUT = 15, PREADY held low.
  - Abort after 16 ACCESS cycles: PSELx and PENABLE drop, done with err = 1 and rdata = 0x00.
  - The next request proceeds normally.
- **Slave error / reset mid-transfer:**
  - PSLVERR = 1 with PREADY gives err = 1 at done.
  - PRESET low during ACCESS immediately drives all outputs to 0 with no done. A fresh req0 after release starts at SETUP.
